// File: rtl/mux_n_to_1_reg_if.sv
// Handshake/data bundle for mux_n_to_1_reg: slave is the selector, master drives sources and sink.
interface mux_n_to_1_reg_if #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned SEL_WIDTH  = 2
);
  logic [NUM_INPUTS*WORD_WIDTH-1:0] in_bus;
  logic                             in_valid;
  logic                             in_ready;
  logic [SEL_WIDTH-1:0]             sel;
  logic                             auto_mode;
  logic [WORD_WIDTH-1:0]            out;
  logic                             out_valid;
  logic                             out_ready;
  logic [SEL_WIDTH-1:0]             out_sel;
  logic                             out_err;

  modport master (
    output in_bus, in_valid, sel, auto_mode, out_ready,
    input  in_ready, out, out_valid, out_sel, out_err
  );

  modport slave (
    input  in_bus, in_valid, sel, auto_mode, out_ready,
    output in_ready, out, out_valid, out_sel, out_err
  );
endinterface

// File: rtl/mux_n_to_1_reg.sv
// Registered N-to-1 word selector with valid/ready handshake and round-robin auto-scan.
// Optional MUX_N_TO_1_HOLD_EN: keep out/out_sel/out_err after the word is taken.
module mux_n_to_1_reg #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned SEL_WIDTH  = 2
) (
  input logic            clk,
  input logic            rst,
  mux_n_to_1_reg_if.slave bus
);

  localparam logic [SEL_WIDTH:0]   NumIn   = (SEL_WIDTH + 1)'(NUM_INPUTS);
  localparam logic [SEL_WIDTH-1:0] LastIdx = SEL_WIDTH'(NUM_INPUTS - 1);

  logic [WORD_WIDTH-1:0] out_q, out_d;
  logic [SEL_WIDTH-1:0]  out_sel_q, out_sel_d;
  logic                  out_err_q, out_err_d;
  logic                  out_valid_q, out_valid_d;
  logic [SEL_WIDTH-1:0]  scan_cnt_q, scan_cnt_d;

  logic                  in_ready;
  logic                  accept;
  logic [SEL_WIDTH-1:0]  idx;
  logic                  idx_legal;
  logic [WORD_WIDTH-1:0] chan;

  assign in_ready  = ~out_valid_q | bus.out_ready;
  assign accept    = bus.in_valid & in_ready;
  assign idx       = bus.auto_mode ? scan_cnt_q : bus.sel;
  assign idx_legal = {1'b0, idx} < NumIn;

  // Compare-and-pick avoids any out-of-range part-select for illegal indices.
  always_comb begin
    chan = '0;
    for (int k = 0; k < int'(NUM_INPUTS); k++) begin
      if (idx == SEL_WIDTH'(k)) chan = bus.in_bus[k*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  always_comb begin
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_d       = idx_legal ? chan : '0;
      out_err_d   = ~idx_legal;
      out_sel_d   = idx;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
`ifndef MUX_N_TO_1_HOLD_EN
      out_d       = '0;
      out_sel_d   = '0;
      out_err_d   = 1'b0;
`endif
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q;
    if (!bus.auto_mode) begin
      scan_cnt_d = '0;
    end else if (accept) begin
      scan_cnt_d = (scan_cnt_q == LastIdx) ? '0 : scan_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_sel_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      scan_cnt_q  <= '0;
    end else begin
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      scan_cnt_q  <= scan_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out       = out_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_valid = out_valid_q;

endmodule
